// File: rtl/fifo_canal.sv
// Single-clock channel FIFO with registered read data and occupancy flags.
// Define FIFO_CANAL_ERROR_EN to build the sticky overflow/underflow error flag.
module fifo_canal #(
  parameter int DATA_WIDTH       = 6,
  parameter int ADDR_WIDTH       = 2,
  parameter int ALMOST_FULL_LVL  = 3,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  // Pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      count     <= count_nxt;
      valid_out <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
    end
  end

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

`ifdef FIFO_CANAL_ERROR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((push && full && !pop) || (pop && empty)) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_canal.sv
// Directed scoreboard bench for fifo_canal.
// Checks data, valid and flags against a queue model every cycle.
module tb_fifo_canal;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_data;
  logic          exp_valid;
  logic          exp_err;

  fifo_canal dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":valid"}, 8'(valid_out), 8'(exp_valid));
    chk({tag, ":data"}, 8'(data_out), 8'(last_data));
    chk({tag, ":full"}, 8'(full), 8'(sb.size() == 4));
    chk({tag, ":empty"}, 8'(empty), 8'(sb.size() == 0));
    chk({tag, ":afull"}, 8'(almost_full), 8'(sb.size() >= 3));
    chk({tag, ":aempty"}, 8'(almost_empty), 8'(sb.size() <= 1));
    chk({tag, ":error"}, 8'(error), 8'(exp_err));
  endtask

  // One clock: drive, update the model, then check 1 time unit after the edge.
  task automatic step(input string tag, input logic p,
                      input logic [DW-1:0] d, input logic q);
    logic pop_ok;
    logic push_ok;
    push    = p;
    data_in = d;
    pop     = q;
    pop_ok  = q && (sb.size() > 0);
    push_ok = p && ((sb.size() < 4) || pop_ok);
`ifdef FIFO_CANAL_ERROR_EN
    if ((p && sb.size() == 4 && !q) || (q && sb.size() == 0)) exp_err = 1'b1;
`endif
    exp_valid = pop_ok;
    if (pop_ok) last_data = sb.pop_front();
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic p, input logic q);
    reset   = 1'b1;
    push    = p;
    pop     = q;
    data_in = 6'h2B;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    sb.delete();
    last_data = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset overrides a simultaneous push and pop.
    do_reset("rst0", 1'b1, 1'b1);

    // Fill, drain.
    step("f1", 1, 6'h11, 0);
    step("f2", 1, 6'h22, 0);
    step("f3", 1, 6'h33, 0);
    step("f4", 1, 6'h24, 0);
    step("d1", 0, 6'h00, 1);
    step("d2", 0, 6'h00, 1);
    step("d3", 0, 6'h00, 1);
    step("d4", 0, 6'h00, 1);
    step("idle1", 0, 6'h00, 0);

    // Overflow drop.
    step("o1", 1, 6'h01, 0);
    step("o2", 1, 6'h02, 0);
    step("o3", 1, 6'h03, 0);
    step("o4", 1, 6'h04, 0);
    step("odrop", 1, 6'h3F, 0);
    for (int i = 0; i < 4; i++) step("odrain", 0, 6'h00, 1);
    step("idle2", 0, 6'h00, 0);

    // Underflow: pop on empty ignored.
    step("upop", 0, 6'h00, 1);

    // Push and pop together on empty: no bypass.
    step("epp", 1, 6'h05, 1);
    step("epop", 0, 6'h00, 1);
    step("idle3", 0, 6'h00, 0);

    // Push and pop together when full.
    step("p1", 1, 6'h0A, 0);
    step("p2", 1, 6'h0B, 0);
    step("p3", 1, 6'h0C, 0);
    step("p4", 1, 6'h0D, 0);
    step("fpp", 1, 6'h2A, 1);
    for (int i = 0; i < 4; i++) step("fdrain", 0, 6'h00, 1);
    step("idle4", 0, 6'h00, 0);

    // Mid-stream reset discards contents.
    step("m1", 1, 6'h15, 0);
    step("m2", 1, 6'h16, 0);
    step("m3", 1, 6'h17, 0);
    do_reset("rst1", 1'b1, 1'b1);
    step("mpush", 1, 6'h07, 0);
    step("mpop", 0, 6'h00, 1);
    step("idle5", 0, 6'h00, 0);

    // 12 pushes interleaved with 12 pops, occupancy toggling 1 <-> 2.
    step("w0", 1, 6'h20, 0);
    for (int i = 1; i < 12; i++) begin
      step("wpush", 1, 6'(6'h20 + i), 0);
      step("wpop", 0, 6'h00, 1);
    end
    step("wlast", 0, 6'h00, 1);
    step("idle6", 0, 6'h00, 0);

    // Random mix of push/pop.
    for (int i = 0; i < 40; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 6'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_canal.md
FIFO_CANAL -- requirements
Module: fifo_canal

Interface
REQ-001 Parameter DATA_WIDTH, default 6, SHALL set the entry width in bits (destination [1:0] plus payload).
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter ALMOST_FULL_LVL, default 3, SHALL set the occupancy at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LVL, default 1, SHALL set the occupancy at or below which almost_empty asserts.
REQ-005 Ports SHALL be exactly as follows:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request; driven combinationally by the downstream arbiter.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a popped entry this cycle.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- almost_full  output  1  occupancy >= ALMOST_FULL_LVL.
- almost_empty  output  1  occupancy <= ALMOST_EMPTY_LVL.
- error  output  1  sticky overflow/underflow flag (see Configuration).
REQ-006 There SHALL be one clock (clk) and one reset (reset); reset SHALL be synchronous and active-high.

Function
REQ-007 Storage SHALL be a DEPTH-entry register array with ADDR_WIDTH-bit write and read pointers and an (ADDR_WIDTH+1)-bit occupancy counter.
REQ-008 Pointers SHALL wrap modulo DEPTH with no gap (DEPTH-1 -> 0).
REQ-009 Accepted push: store data_in at wr_ptr; wr_ptr += 1.
REQ-010 Accepted pop: data_out <= mem[rd_ptr], valid_out <= 1 on the next edge (1-cycle read latency); rd_ptr += 1.
REQ-011 valid_out SHALL be 0 on any cycle following a cycle with no accepted pop; data_out SHALL hold its last value.
REQ-012 Push when full without pop SHALL be dropped: memory, pointers and count unchanged.
REQ-013 Pop when empty SHALL be ignored: rd_ptr and count unchanged, valid_out 0 next cycle.
REQ-014 Push and pop together, not empty: both accepted, count unchanged; when full, both accepted and full stays 1.
REQ-015 Push and pop together when empty: push accepted, pop ignored (no bypass); count becomes 1.
REQ-016 Count SHALL be +1 (push only), -1 (pop only), or unchanged; it SHALL never exceed DEPTH or go below 0.
REQ-017 full, empty, almost_full and almost_empty SHALL be decoded from the registered count only (glitch-free, no combinational path from push/pop).

Reset
REQ-018 With reset high at a rising edge: pointers 0, count 0, data_out 0, valid_out 0, error 0; empty=1, almost_empty=1, full=0, almost_full=0 from the following cycle.
REQ-019 Reset SHALL override simultaneous push/pop; memory contents need not be cleared.
REQ-020 Reset asserted mid-stream SHALL discard all stored entries; the first push after reset SHALL be the first entry popped.

Configuration
REQ-021 With macro FIFO_CANAL_ERROR_EN defined: error SHALL be set on the edge after a dropped push (REQ-012) or an ignored pop (REQ-013) and SHALL remain 1 until reset.
REQ-022 Without FIFO_CANAL_ERROR_EN: error SHALL be tied to 0 and no error-detect logic SHALL be synthesized; all other behaviour is identical.

Verification
REQ-023 Reset, then push 0x11,0x22,0x33,0x24 on 4 cycles -> full=1, almost_full=1 after 4th edge; 4 pops return 0x11,0x22,0x33,0x24 each one cycle after pop with valid_out=1; then empty=1.
REQ-024 Fill to 4, push 0x3F without pop -> entry dropped, count stays 4; drain yields original 4 values; error=1 only with FIFO_CANAL_ERROR_EN.
REQ-025 Empty, assert push=1 with data_in=0x05 and pop=1 in the same cycle -> count=1, valid_out=0 next cycle; next pop returns 0x05.
REQ-026 Full, push 0x2A with pop in the same cycle -> oldest entry out, full stays 1; 0x2A returned as 4th pop afterwards.
REQ-027 Push 3 entries (almost_full=1), assert reset one cycle -> empty=1, count 0, valid_out=0, error=0; push 0x07, pop -> data_out=0x07.
REQ-028 12 pushes interleaved with 12 pops (pointer wrap 3x) -> output order equals input order, almost_empty toggles at occupancy 1/2 boundary.
